// File: rtl/scl180_sparecell_tiemon.sv
// Tie-off integrity monitor for SCL180 spare-cell LO outputs: synchronises the
// tie-low lines, waits a settle window, then records sticky faults and glitch counts.
module scl180_sparecell_tiemon #(
    parameter int NUM_CELLS     = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NUM_CELLS-1:0] lo_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    output logic                 ok_o,
    output logic                 busy_o,
    output logic                 fault_o,
    output logic [NUM_CELLS-1:0] fault_mask_o,
    output logic [CNT_W-1:0]     glitch_cnt_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_MONITOR = 2'd2;
    localparam logic [1:0] ST_FAULT   = 2'd3;

    localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [NUM_CELLS-1:0] s1_q, s2_q;
    logic                 prev_q, prev_d;
    logic [1:0]           state_q, state_d;
    logic [15:0]          settle_q, settle_d;
    logic                 fault_q, fault_d;
    logic [NUM_CELLS-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]     glitch_q, glitch_d;
    logic                 any_hi;
    logic                 rise;

    assign any_hi = |s2_q;
    assign rise   = any_hi & ~prev_q;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        fault_d  = fault_q;
        mask_d   = mask_q;
        glitch_d = glitch_q;
        // Holding prev low through SETTLE makes a stuck-high line count on the first MONITOR cycle.
        prev_d   = (state_q == ST_SETTLE) ? 1'b0 : any_hi;

        if (state_q != ST_IDLE && !en_i) begin
            state_d  = ST_IDLE;
            settle_d = '0;
        end else if (clr_i) begin
            fault_d  = 1'b0;
            mask_d   = '0;
            glitch_d = '0;
            settle_d = '0;
            state_d  = en_i ? ST_SETTLE : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_i) begin
                        state_d  = ST_SETTLE;
                        settle_d = '0;
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d  = ST_MONITOR;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + 16'd1;
                    end
                end
                ST_MONITOR, ST_FAULT: begin
                    if (any_hi) begin
                        mask_d  = mask_q | s2_q;
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end
                    if (rise && glitch_q != CNT_MAX) begin
                        glitch_d = glitch_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s1_q     <= '0;
            s2_q     <= '0;
            prev_q   <= 1'b0;
            state_q  <= ST_IDLE;
            settle_q <= '0;
            fault_q  <= 1'b0;
            mask_q   <= '0;
            glitch_q <= '0;
        end else begin
            s1_q     <= lo_i;
            s2_q     <= s1_q;
            prev_q   <= prev_d;
            state_q  <= state_d;
            settle_q <= settle_d;
            fault_q  <= fault_d;
            mask_q   <= mask_d;
            glitch_q <= glitch_d;
        end
    end

    assign ok_o         = (state_q == ST_MONITOR) & ~fault_q;
    assign busy_o       = (state_q == ST_SETTLE);
    assign fault_o      = fault_q;
    assign fault_mask_o = mask_q;
    assign glitch_cnt_o = glitch_q;

endmodule

// File: tb/tb_scl180_sparecell_tiemon.sv
// Scoreboarded bench: a behavioural monitor model predicts every post-edge output
// set, a separate monitor process pops and compares after each rising edge.
module tb_scl180_sparecell_tiemon;

    localparam int NC   = 4;
    localparam int SC   = 16;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    localparam int M_IDLE = 0;
    localparam int M_SET  = 1;
    localparam int M_MON  = 2;
    localparam int M_FLT  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic          clr = 1'b0;
    logic [NC-1:0] lo  = '0;
    logic          ok, busy, fault;
    logic [NC-1:0] mask;
    logic [CW-1:0] gcnt;

    always #5 clk = ~clk;

    scl180_sparecell_tiemon #(.NUM_CELLS(NC), .SETTLE_CYCLES(SC), .CNT_W(CW)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .lo_i        (lo),
        .en_i        (en),
        .clr_i       (clr),
        .ok_o        (ok),
        .busy_o      (busy),
        .fault_o     (fault),
        .fault_mask_o(mask),
        .glitch_cnt_o(gcnt)
    );

    typedef struct packed {
        logic          ok;
        logic          busy;
        logic          fault;
        logic [NC-1:0] mask;
        logic [CW-1:0] cnt;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    done   = 1'b0;
    string phase  = "reset";

    // Reference model: lines seen two edges late, a countdown settle window,
    // and sticky status that only clear/reset can wipe.
    int            m_mode = M_IDLE;
    int            m_left = 0;
    bit            m_fault = 1'b0;
    bit [NC-1:0]   m_mask = '0;
    int            m_cnt = 0;
    bit            m_last = 1'b0;
    bit [NC-1:0]   m_pipe[$] = '{'0, '0};

    task automatic model_step();
        bit [NC-1:0] seen;
        bit          any_hi, rise, nlast;
        obs_t        e;
        seen   = m_pipe[0];
        any_hi = |seen;
        rise   = any_hi && !m_last;
        nlast  = (m_mode == M_SET) ? 1'b0 : any_hi;
        if (rst) begin
            m_mode = M_IDLE; m_left = 0; m_fault = 0; m_mask = '0; m_cnt = 0; m_last = 0;
            m_pipe.delete();
            m_pipe.push_back('0);
            m_pipe.push_back('0);
        end else begin
            if (m_mode != M_IDLE && !en) begin
                m_mode = M_IDLE;
            end else if (clr) begin
                m_fault = 0; m_mask = '0; m_cnt = 0;
                if (en) begin m_mode = M_SET; m_left = SC; end
                else m_mode = M_IDLE;
            end else begin
                case (m_mode)
                    M_IDLE: if (en) begin m_mode = M_SET; m_left = SC; end
                    M_SET: begin
                        m_left--;
                        if (m_left == 0) m_mode = M_MON;
                    end
                    default: begin
                        if (any_hi) begin m_mask |= seen; m_fault = 1; m_mode = M_FLT; end
                        if (rise && m_cnt < CMAX) m_cnt++;
                    end
                endcase
            end
            m_pipe.push_back(lo);
            void'(m_pipe.pop_front());
            m_last = nlast;
        end
        e.ok    = (m_mode == M_MON) && !m_fault;
        e.busy  = (m_mode == M_SET);
        e.fault = m_fault;
        e.mask  = m_mask;
        e.cnt   = CW'(m_cnt);
        exp_q.push_back(e);
        tag_q.push_back(phase);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic run_to_monitor(input string name);
        int n;
        n = 0;
        while (m_mode != M_MON && n < 100) begin cycle(); n++; end
        if (m_mode != M_MON) begin
            checks++; errors++;
            $display("FAIL %s: settle window never ended within 100 cycles", name);
        end
    endtask

    initial begin : monitor
        obs_t  e, a;
        string t;
        while (!done) begin
            @(posedge clk);
            #1;
            if (!done) begin
                checks++;
                a = '{ok, busy, fault, mask, gcnt};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: output present with no expectation");
                end else begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    if (a !== e)
                        $display("FAIL %s @%0t: actual ok=%0b busy=%0b fault=%0b mask=%b cnt=%0d required ok=%0b busy=%0b fault=%0b mask=%b cnt=%0d",
                                 t, $time, a.ok, a.busy, a.fault, a.mask, a.cnt, e.ok, e.busy, e.fault, e.mask, e.cnt);
                    if (a !== e) errors++;
                end
            end
        end
    end

    initial begin : driver
        // Reset and idle
        rst = 1'b1; cycle(); cycle();
        rst = 1'b0;
        phase = "idle";
        repeat (100) cycle();

        // Settle timing with quiet lines
        phase = "settle";
        en = 1'b1; cycle();
        chk("settle_busy_start", busy, 1);
        repeat (SC - 1) cycle();
        chk("settle_busy_last", busy, 1);
        chk("settle_ok_before", ok, 0);
        cycle();
        chk("settle_ok_rise", ok, 1);
        chk("settle_busy_end", busy, 0);
        phase = "quiet_monitor";
        repeat (200) cycle();
        chk("quiet_fault", fault, 0);

        // Stuck-high line present before enable
        phase = "stuck_high";
        en = 1'b0; lo = 4'b0100;
        repeat (3) cycle();
        en = 1'b1;
        run_to_monitor("stuck_settle");
        repeat (3) cycle();
        chk("stuck_fault", fault, 1);
        chk("stuck_mask", mask, 4'b0100);
        chk("stuck_cnt", gcnt, 1);

        // Clear, resettle, then saturate the counter with five pulses
        phase = "saturate";
        lo = '0; clr = 1'b1; cycle(); clr = 1'b0;
        chk("clr_mask", mask, 0);
        run_to_monitor("sat_settle");
        for (int p = 0; p < 5; p++) begin
            lo = (p % 2 == 0) ? 4'b0001 : 4'b1000;
            repeat (3) cycle();
            lo = '0;
            repeat (4) cycle();
        end
        chk("sat_cnt", gcnt, 3);
        chk("sat_mask", mask, 4'b1001);
        chk("sat_fault", fault, 1);

        // Clear collides with a fresh rising event
        phase = "collision";
        lo = 4'b0010; cycle(); cycle();
        clr = 1'b1; cycle(); clr = 1'b0;
        lo = '0;
        chk("coll_fault", fault, 0);
        chk("coll_mask", mask, 0);
        chk("coll_cnt", gcnt, 0);
        chk("coll_busy", busy, 1);
        repeat (SC - 1) cycle();
        chk("coll_ok_early", ok, 0);
        cycle();
        chk("coll_ok", ok, 1);

        // Disable in FAULT keeps status; re-enable; reset during settle
        phase = "disable";
        lo = 4'b0010; repeat (3) cycle();
        lo = '0; repeat (4) cycle();
        en = 1'b0; cycle();
        chk("dis_busy", busy, 0);
        chk("dis_ok", ok, 0);
        chk("dis_fault", fault, 1);
        chk("dis_mask", mask, 4'b0010);
        chk("dis_cnt", gcnt, 1);
        en = 1'b1; cycle();
        chk("reen_busy", busy, 1);
        repeat (4) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_mask", mask, 0);
        chk("rst_cnt", gcnt, 0);

        // Randomised traffic
        phase = "random";
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) en = ~en;
            clr = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0)
                lo = ($urandom_range(0, 1) == 0) ? '0 : NC'($urandom);
            cycle();
        end
        clr = 1'b0; rst = 1'b0;

        done = 1'b1;
        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
